// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined RISC-V immediate generator.
// Holds the immediate format enum, major opcode values and the XLEN legality check.
package imm_gen_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic logic xlen_valid(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-to-immediate decoder: classifies the encoding format,
// flags illegal/non-32-bit encodings and builds the sign/zero-extended immediate.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst_i,
  output logic [XLEN-1:0]   imm_c,
  output fmt_e              fmt_c,
  output logic              illegal_c
);

  localparam logic IS_RV64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [31:0] raw_imm;
  logic        unused_funct3_lo;

  assign opcode           = inst_i[6:0];
  assign unused_funct3_lo = ^inst_i[13:12];

  // Format classification; anything outside the supported opcode map is illegal
  always_comb begin
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: fmt_c = FMT_I;
      OPC_OP_IMM_32: begin
        if (IS_RV64) fmt_c = FMT_I;
        else         illegal_c = 1'b1;
      end
      OPC_SYSTEM:        fmt_c = inst_i[14] ? FMT_Z : FMT_I;
      OPC_STORE:         fmt_c = FMT_S;
      OPC_BRANCH:        fmt_c = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
      OPC_JAL:           fmt_c = FMT_J;
      OPC_OP:            fmt_c = FMT_NONE;
      OPC_OP_32:         illegal_c = !IS_RV64;
      default:           illegal_c = 1'b1;
    endcase
    // Compressed/reserved length encodings are never legal here
    if (inst_i[1:0] != 2'b11) begin
      fmt_c     = FMT_NONE;
      illegal_c = 1'b1;
    end
  end

  // 32-bit immediate already sign-extended to bit 31 (Z is zero-extended)
  always_comb begin
    raw_imm = '0;
    case (fmt_c)
      FMT_I: raw_imm = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: raw_imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: raw_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      FMT_U: raw_imm = {inst_i[31:12], 12'b0};
      FMT_J: raw_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      FMT_Z: raw_imm = {27'b0, inst_i[19:15]};
      default: raw_imm = '0;
    endcase
  end

  assign imm_c = XLEN'($signed(raw_imm));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeding a main + skid output buffer with
// valid/ready handshakes and flush. Optional perf counters under IMMGEN_PERF_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output fmt_e              out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
`ifdef IMMGEN_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_total,
  output logic [PERF_W-1:0] perf_illegal
`endif
);

  if (!xlen_valid(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (in_inst),
    .imm_c     (dec_imm),
    .fmt_c     (dec_fmt),
    .illegal_c (dec_illegal)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  fmt_e             main_fmt_q,   main_fmt_d;
  logic             main_ill_q,   main_ill_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  fmt_e             skid_fmt_q,   skid_fmt_d;
  logic             skid_ill_q,   skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic in_fire;
  logic out_fire;

  // in_ready depends only on registered skid occupancy, never on out_ready
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & out_ready;

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;

  // Buffer next-state: flush wins, then drain/promote, then accept
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        if (skid_valid_q) begin
          main_imm_d   = skid_imm_q;
          main_fmt_d   = skid_fmt_q;
          main_ill_d   = skid_ill_q;
          main_tag_d   = skid_tag_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      if (in_fire) begin
        // in_fire implies skid empty, so a draining main can take the new entry directly
        if (!main_valid_q || out_fire) begin
          main_valid_d = 1'b1;
          main_imm_d   = dec_imm;
          main_fmt_d   = dec_fmt;
          main_ill_d   = dec_illegal;
          main_tag_d   = in_tag;
        end else begin
          skid_valid_d = 1'b1;
          skid_imm_d   = dec_imm;
          skid_fmt_d   = dec_fmt;
          skid_ill_d   = dec_illegal;
          skid_tag_d   = in_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_ill_q   <= 1'b0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

`ifdef IMMGEN_PERF_EN
  logic [PERF_W-1:0] perf_total_q, perf_total_d;
  logic [PERF_W-1:0] perf_ill_q,   perf_ill_d;

  // Saturating handshake counters; a flushed cycle's handshake is not counted
  always_comb begin
    perf_total_d = perf_total_q;
    perf_ill_d   = perf_ill_q;
    if (out_fire && !flush) begin
      if (perf_total_q != '1) perf_total_d = perf_total_q + PERF_W'(1);
      if (main_ill_q && (perf_ill_q != '1)) perf_ill_d = perf_ill_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total_q <= '0;
      perf_ill_q   <= '0;
    end else begin
      perf_total_q <= perf_total_d;
      perf_ill_q   <= perf_ill_d;
    end
  end

  assign perf_total   = perf_total_q;
  assign perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32 and an RV64 instance share the same
// stimulus; each has its own expected-entry queue fed by an arithmetic reference model.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int unsigned TAG_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             ir32, ov32, il32, ir64, ov64, il64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  fmt_e             f32, f64;
  logic [TAG_W-1:0] t32, t64;

  logic             ir [2];
  logic             ov [2];
  logic             il [2];
  logic [63:0]      im [2];
  logic [2:0]       fm [2];
  logic [TAG_W-1:0] tg [2];

  assign ir[0] = ir32;  assign ir[1] = ir64;
  assign ov[0] = ov32;  assign ov[1] = ov64;
  assign il[0] = il32;  assign il[1] = il64;
  assign im[0] = {32'b0, imm32};  assign im[1] = imm64;
  assign fm[0] = f32;   assign fm[1] = f64;
  assign tg[0] = t32;   assign tg[1] = t64;

`ifdef IMMGEN_PERF_EN
  logic [31:0] pt32, pi32, pt64, pi64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(f32), .out_illegal(il32), .out_tag(t32)
`ifdef IMMGEN_PERF_EN
    , .perf_total(pt32), .perf_illegal(pi32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(f64), .out_illegal(il64), .out_tag(t64)
`ifdef IMMGEN_PERF_EN
    , .perf_total(pt64), .perf_illegal(pi64)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  // Reference decode from the encoding rules using plain integer arithmetic
  function automatic exp_t model(input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                                 input bit x64);
    exp_t   e;
    longint s, v;
    s     = longint'($signed(inst));
    v     = 0;
    e.fmt = FMT_NONE;
    e.ill = 1'b0;
    e.tag = tag;
    if (inst[1:0] != 2'b11) e.ill = 1'b1;
    else begin
      case (inst[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F: begin e.fmt = FMT_I; v = s >>> 20; end
        7'h1B: if (x64) begin e.fmt = FMT_I; v = s >>> 20; end else e.ill = 1'b1;
        7'h73: if (inst[14]) begin e.fmt = FMT_Z; v = longint'(inst[19:15]); end
               else begin e.fmt = FMT_I; v = s >>> 20; end
        7'h23: begin e.fmt = FMT_S; v = (s >>> 25) * 32 + longint'(inst[11:7]); end
        7'h63: begin
          e.fmt = FMT_B;
          v = (s >>> 31) * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
              + longint'(inst[11:8]) * 2;
        end
        7'h37, 7'h17: begin e.fmt = FMT_U; v = (s >>> 12) * 4096; end
        7'h6F: begin
          e.fmt = FMT_J;
          v = (s >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
              + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        end
        7'h33: e.fmt = FMT_NONE;
        7'h3B: e.ill = !x64;
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    return e;
  endfunction

  logic [TAG_W-1:0] seen_tags [$];

  for (genvar g = 0; g < 2; g++) begin : g_mon
    exp_t             q [$];
    exp_t             e;
    logic             stall = 1'b0;
    logic [63:0]      s_im;
    logic [2:0]       s_fm;
    logic             s_il;
    logic [TAG_W-1:0] s_tg;
`ifdef IMMGEN_PERF_EN
    int n_tot = 0;
    int n_ill = 0;
`endif

    // Edge monitor: pop/compare on output handshake, push model result on input handshake
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        stall = 1'b0;
`ifdef IMMGEN_PERF_EN
        n_tot = 0;
        n_ill = 0;
`endif
      end else if (flush) begin
        q.delete();
        stall = 1'b0;
      end else begin
        if (ov[g] && out_ready) begin
          if (q.size() == 0) check($sformatf("spurious_out%0d", g), 64'(ov[g]), 64'(0));
          else begin
            e = q.pop_front();
            check($sformatf("imm%0d_tag%0h", g, e.tag), im[g], e.imm);
            check($sformatf("fmt%0d_tag%0h", g, e.tag), 64'(fm[g]), 64'(e.fmt));
            check($sformatf("ill%0d_tag%0h", g, e.tag), 64'(il[g]), 64'(e.ill));
            check($sformatf("tag%0d", g), 64'(tg[g]), 64'(e.tag));
            if (g == 0) seen_tags.push_back(e.tag);
`ifdef IMMGEN_PERF_EN
            n_tot++;
            if (e.ill) n_ill++;
`endif
          end
        end
        if (in_valid && ir[g]) q.push_back(model(in_inst, in_tag, g == 1));
        stall = ov[g] && !out_ready;
        s_im  = im[g];
        s_fm  = fm[g];
        s_il  = il[g];
        s_tg  = tg[g];
      end
    end

    // Mid-cycle monitor: occupancy vs model and hold-stable under stall
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        check($sformatf("out_valid_occ%0d", g), 64'(ov[g]), 64'(q.size() > 0));
        check($sformatf("in_ready_occ%0d", g), 64'(ir[g]), 64'(q.size() < 2));
        if (stall) begin
          check($sformatf("stall_valid%0d", g), 64'(ov[g]), 64'(1));
          check($sformatf("stall_imm%0d", g), im[g], s_im);
          check($sformatf("stall_fmt%0d", g), 64'(fm[g]), 64'(s_fm));
          check($sformatf("stall_ill%0d", g), 64'(il[g]), 64'(s_il));
          check($sformatf("stall_tag%0d", g), 64'(tg[g]), 64'(s_tg));
        end
      end
    end
  end

  bit rflush = 1'b0;
  bit done = 1'b0;

  // Present one instruction from a negedge until accepted; returns at a negedge
  task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    n = 0;
    do begin
      flush = rflush && ($urandom_range(0, 39) == 0);
      acc   = ir32 && !flush;
      @(negedge clk);
      n++;
    end while (!acc && n < 300);
    flush    = 1'b0;
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic directed(input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                          input logic [31:0] e32, input logic [2:0] fmt32, input logic ill32,
                          input logic [63:0] e64, input logic [2:0] fmt64, input logic ill64);
    send(inst, tag);
    check($sformatf("dir_valid32_%08h", inst), 64'(ov32), 64'(1));
    check($sformatf("dir_valid64_%08h", inst), 64'(ov64), 64'(1));
    check($sformatf("dir_imm32_%08h", inst), 64'(imm32), 64'(e32));
    check($sformatf("dir_imm64_%08h", inst), imm64, e64);
    check($sformatf("dir_fmt32_%08h", inst), 64'(f32), 64'(fmt32));
    check($sformatf("dir_fmt64_%08h", inst), 64'(f64), 64'(fmt64));
    check($sformatf("dir_ill32_%08h", inst), 64'(il32), 64'(ill32));
    check($sformatf("dir_ill64_%08h", inst), 64'(il64), 64'(ill64));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [13];
    logic [31:0] r;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B,
            7'h63, 7'h67, 7'h6F, 7'h73};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid32", 64'(ov32), 64'(0));
    check("rst_valid64", 64'(ov64), 64'(0));
    check("rst_imm64", imm64, 64'(0));
    check("rst_imm32", 64'(imm32), 64'(0));
    check("rst_fmt64", 64'(f64), 64'(FMT_NONE));
    check("rst_ill64", 64'(il64), 64'(0));
    check("rst_tag64", 64'(t64), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready32", 64'(ir32), 64'(1));
    check("rst_in_ready64", 64'(ir64), 64'(1));

    out_ready = 1'b1;
    directed(32'h0000_0000, 16'h10, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
    directed(32'h0000_0013, 16'h11, 32'h0, FMT_I, 1'b0, 64'h0, FMT_I, 1'b0);
    @(negedge clk);
`ifdef IMMGEN_PERF_EN
    check("perf_total32", 64'(pt32), 64'(2));
    check("perf_illegal32", 64'(pi32), 64'(1));
    check("perf_total64", 64'(pt64), 64'(2));
    check("perf_illegal64", 64'(pi64), 64'(1));
`endif
    directed(32'hFFF0_0093, 16'h12, 32'hFFFF_FFFF, FMT_I, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    directed(32'hFE11_2E23, 16'h13, 32'hFFFF_FFFC, FMT_S, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S, 1'b0);
    directed(32'hFF9F_F06F, 16'h14, 32'hFFFF_FFF8, FMT_J, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, FMT_J, 1'b0);
    directed(32'hFE00_0EE3, 16'h15, 32'hFFFF_FFFC, FMT_B, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0);
    directed(32'h8000_00B7, 16'h16, 32'h8000_0000, FMT_U, 1'b0, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
    directed(32'h300F_D073, 16'h17, 32'h0000_001F, FMT_Z, 1'b0, 64'h1F, FMT_Z, 1'b0);
    directed(32'h0000_001B, 16'h18, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_I, 1'b0);
    directed(32'h0000_003B, 16'h19, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b0);
    directed(32'h0020_80B3, 16'h1A, 32'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0);
    @(negedge clk);

    // Back-pressure: two accepted, then in_ready drops until the consumer drains
    out_ready = 1'b0;
    seen_tags.delete();
    send(32'hFFF0_0093, 16'd0);
    send(32'hFE11_2E23, 16'd1);
    check("bp_in_ready_low", 64'(ir32), 64'(0));
    fork
      begin
        send(32'hFF9F_F06F, 16'd2);
        send(32'h8000_00B7, 16'd3);
      end
      begin
        repeat (3) begin
          check("bp_hold_tag", 64'(t64), 64'(0));
          check("bp_hold_ready", 64'(ir64), 64'(0));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("bp_count", 64'(seen_tags.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < seen_tags.size()) check($sformatf("bp_order%0d", i), 64'(seen_tags[i]), 64'(i));
    end

    // Flush with both entries full and a same-cycle input
    out_ready = 1'b0;
    send(32'h0010_0093, 16'h20);
    send(32'h0020_0093, 16'h21);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0030_0093; in_tag = 16'h99;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_valid32", 64'(ov32), 64'(0));
    check("flush_full_valid64", 64'(ov64), 64'(0));
    check("flush_full_ready", 64'(ir64), 64'(1));
    // Flush with one entry while the block could accept the input
    send(32'h0040_0093, 16'h22);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093; in_tag = 16'h77;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_valid64", 64'(ov64), 64'(0));
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_no_ghost", 64'(ov64), 64'(0));
    end

    // Asynchronous reset while both entries are occupied
    out_ready = 1'b0;
    send(32'h0060_0093, 16'h30);
    send(32'h0070_0093, 16'h31);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid32", 64'(ov32), 64'(0));
    check("arst_valid64", 64'(ov64), 64'(0));
    check("arst_ready64", 64'(ir64), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_post_ready", 64'(ir32), 64'(1));
`ifdef IMMGEN_PERF_EN
    check("arst_perf_total", 64'(pt64), 64'(0));
`endif

    // Random traffic with random back-pressure and occasional flush
    rflush = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) send(rand_inst(), TAG_W'(i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    rflush = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("drain_empty32", 64'(ov32), 64'(0));
    check("drain_empty64", 64'(ov64), 64'(0));
`ifdef IMMGEN_PERF_EN
    check("perf_total32_end", 64'(pt32), 64'(g_mon[0].n_tot));
    check("perf_illegal32_end", 64'(pi32), 64'(g_mon[0].n_ill));
    check("perf_total64_end", 64'(pt64), 64'(g_mon[1].n_tot));
    check("perf_illegal64_end", 64'(pi64), 64'(g_mon[1].n_ill));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
